bank_conflict_scheduler: RTL

BANK_CONFLICT_SCHEDULER -- requirements
Module: bank_conflict_scheduler

---
 rtl/bank_conflict_scheduler.sv | 112 +++++++++++
 1 files changed

// File: rtl/bank_conflict_scheduler.sv
// rtl/bank_conflict_scheduler.sv - routes one lane group to banks, serialising lanes that share a bank
module bank_conflict_scheduler #(
    parameter int NB = 4,
    parameter int LW = $clog2(NB),
    parameter int DW = 12,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NB*LW-1:0] in_bank,
    input  logic [NB*DW-1:0] in_data,
    output logic [NB-1:0]    out_valid,
    output logic [NB*LW-1:0] out_sel,
    output logic [NB*DW-1:0] out_data,
    output logic             out_last,
    output logic [CW-1:0]    conflict_cnt
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NB-1:0]      r_pending;
    logic [NB*LW-1:0]   r_bank;
    logic [NB*DW-1:0]   r_data;

    logic [NB-1:0]      w_bank_hit;
    logic [NB*LW-1:0]   w_sel;
    logic [NB*DW-1:0]   w_data;
    logic [NB-1:0]      w_granted;
    logic               w_round_last;
    logic               w_accept;

    // Per bank, the lowest-indexed pending lane wins; a bank's hit bit stops further matches.
    always_comb begin
        w_bank_hit = '0;
        w_sel      = '0;
        w_data     = '0;
        w_granted  = '0;
        if (r_state == SERVE) begin
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < NB; i++) begin
                    if (!w_bank_hit[b] && r_pending[i] && (r_bank[i*LW +: LW] == LW'(b))) begin
                        w_bank_hit[b]         = 1'b1;
                        w_sel[b*LW +: LW]     = LW'(i);
                        w_data[b*DW +: DW]    = r_data[i*DW +: DW];
                        w_granted[i]          = 1'b1;
                    end
                end
            end
        end
    end

    assign w_round_last = (r_state == SERVE) && ((r_pending & ~w_granted) == '0);
    assign in_ready     = !rst && ((r_state == IDLE) || w_round_last);
    assign w_accept     = in_valid && in_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = SERVE;
            SERVE:   if (w_round_last && !w_accept) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_bank       <= '0;
            r_data       <= '0;
            out_valid    <= '0;
            out_sel      <= '0;
            out_data     <= '0;
            out_last     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (r_state == SERVE) begin
                out_valid <= w_bank_hit;
                out_sel   <= w_sel;
                out_data  <= w_data;
                out_last  <= w_round_last;
                r_pending <= r_pending & ~w_granted;
                if (!w_round_last && (conflict_cnt != {CW{1'b1}})) begin
                    conflict_cnt <= conflict_cnt + CW'(1);
                end
            end else begin
                out_valid <= '0;
                out_sel   <= '0;
                out_data  <= '0;
                out_last  <= 1'b0;
            end
            // A new group overrides the drained pending mask on the same edge.
            if (w_accept) begin
                r_bank    <= in_bank;
                r_data    <= in_data;
                r_pending <= '1;
            end
        end
    end

endmodule
